// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite bitmap loader: loader state encoding and
// address-width helper.
package sprite_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StDiscard = 3'd2,
    StPending = 3'd3,
    StClear   = 3'd4
  } state_e;

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_dp_async.sv
// Simple dual-port RAM: synchronous write port, asynchronous (combinational)
// read port. No reset on contents.
module ram_dp_async
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 128,
  localparam int unsigned AW   = addr_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Sized to the full address space so a bank-select MSB over a
  // non-power-of-two bank depth never indexes out of range.
  logic [WIDTH-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sprite_loader.sv
// Sprite bitmap loader: streams a bitmap into the hidden bank of a double-banked
// RAM and swaps banks on a frame pulse. Optional clear: SPRITE_LOADER_CLEAR_EN.
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_WIDTH  = 8,
  parameter int unsigned SPR_HEIGHT = 8,
  parameter int unsigned SPR_DATAW  = 1,
  localparam int unsigned DEPTH     = SPR_WIDTH * SPR_HEIGHT,
  localparam int unsigned AW        = addr_width(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [SPR_DATAW-1:0] i_in_data,
  input  logic                 i_in_last,
  input  logic                 i_frame,
`ifdef SPRITE_LOADER_CLEAR_EN
  input  logic                 i_clear,
`endif
  input  logic [AW-1:0]        i_rd_addr,
  output logic [SPR_DATAW-1:0] o_rd_data,
  output logic                 o_pending,
  output logic                 o_err
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e               r_state, w_state_nxt;
  logic                 r_disp_bank, w_disp_bank_nxt;
  logic [AW-1:0]        r_wr_addr, w_wr_addr_nxt;
  logic                 r_err, w_err_nxt;
  logic                 w_we;
  logic [SPR_DATAW-1:0] w_wdata;
  logic                 w_accept;
  logic                 w_clear_req;

`ifdef SPRITE_LOADER_CLEAR_EN
  assign w_clear_req = i_clear && (r_state == StIdle);
`else
  assign w_clear_req = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_disp_bank_nxt = r_disp_bank;
    w_wr_addr_nxt   = r_wr_addr;
    w_err_nxt       = r_err;
    w_we            = 1'b0;
    w_wdata         = i_in_data;
    o_in_ready      = 1'b0;

    // A clear request in IDLE wins over a stream word, so no word is silently lost.
    case (r_state)
      StIdle, StLoad, StDiscard: o_in_ready = !w_clear_req;
      default:                   o_in_ready = 1'b0;
    endcase
    if (i_rst) begin
      o_in_ready = 1'b0;
    end
    w_accept = i_in_valid && o_in_ready;

    case (r_state)
      StIdle, StLoad: begin
        if (w_clear_req) begin
          w_state_nxt = StClear;
        end else if (w_accept) begin
          w_we = 1'b1;
          if (i_in_last) begin
            w_wr_addr_nxt = '0;
            if (r_wr_addr == LastAddr) begin
              w_state_nxt = StPending;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = StIdle;
            end
          end else if (r_wr_addr == LastAddr) begin
            w_err_nxt     = 1'b1;
            w_wr_addr_nxt = '0;
            w_state_nxt   = StDiscard;
          end else begin
            w_wr_addr_nxt = r_wr_addr + 1'b1;
            w_state_nxt   = StLoad;
          end
        end
      end
      StDiscard: begin
        if (w_accept && i_in_last) begin
          w_wr_addr_nxt = '0;
          w_state_nxt   = StIdle;
        end
      end
      StPending: begin
        if (i_frame) begin
          w_disp_bank_nxt = !r_disp_bank;
          w_err_nxt       = 1'b0;
          w_state_nxt     = StIdle;
        end
      end
`ifdef SPRITE_LOADER_CLEAR_EN
      StClear: begin
        w_we    = 1'b1;
        w_wdata = '0;
        if (r_wr_addr == LastAddr) begin
          w_wr_addr_nxt = '0;
          w_state_nxt   = StPending;
        end else begin
          w_wr_addr_nxt = r_wr_addr + 1'b1;
        end
      end
`endif
      default: begin
        w_wr_addr_nxt = '0;
        w_state_nxt   = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_disp_bank <= 1'b0;
      r_wr_addr   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_disp_bank <= w_disp_bank_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_pending = (r_state == StPending);
  assign o_err     = r_err;

  // Bank bit is the RAM address MSB; writes always go to the hidden bank.
  ram_dp_async #(
    .WIDTH (SPR_DATAW),
    .DEPTH (2 * DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr ({!r_disp_bank, r_wr_addr}),
    .i_wdata (w_wdata),
    .i_raddr ({r_disp_bank, i_rd_addr}),
    .o_rdata (o_rd_data)
  );

endmodule

// File: tb/tb_sprite_loader.sv
// Randomized self-checking bench for sprite_loader (8x8x1) against a
// transfer-level model of the two bitmap banks.
module tb_sprite_loader;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_data;
  logic       in_last;
  logic       frame;
  logic       clear;
  logic [5:0] rd_addr;
  logic [0:0] rd_data;
  logic       pending;
  logic       err;

  always #5 clk = ~clk;

  sprite_loader dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .i_in_last  (in_last),
    .i_frame    (frame),
`ifdef SPRITE_LOADER_CLEAR_EN
    .i_clear    (clear),
`endif
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_pending  (pending),
    .o_err      (err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: two banks of pixels, which one is shown, and the flag outputs.
  logic [0:0] ref_bank  [2][DEPTH];
  bit         ref_known [2][DEPTH];
  int         ref_disp;
  bit         ref_pend;
  bit         ref_err;

  // Stream n words (last on word n-1); mode 0: addr[0], 1: all ones, else random.
  task automatic stream(input int n, input int mode, input bit gaps, input bit coinc,
                        input string tag);
    int wb;
    wb = 1 - ref_disp;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat ($urandom_range(2)) @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      frame    = coinc && (i == n - 1);
      case (mode)
        0:       in_data = 1'(i & 1);
        1:       in_data = 1'b1;
        default: in_data = 1'($urandom_range(1));
      endcase
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL %s ready word %0d: got %b want 1", tag, i, in_ready);
      end
      if (i < DEPTH) begin
        ref_bank[wb][i]  = in_data;
        ref_known[wb][i] = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    frame    = 1'b0;
    if (n == DEPTH) ref_pend = 1'b1;
    else            ref_err  = 1'b1;
    #1;
    n_vec += 2;
    if (pending !== ref_pend) begin
      n_err++;
      $display("FAIL %s pending: got %b want %b", tag, pending, ref_pend);
    end
    if (err !== ref_err) begin
      n_err++;
      $display("FAIL %s err: got %b want %b", tag, err, ref_err);
    end
    // Loading must never disturb the shown bitmap.
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 6'(a);
      #1;
      if (ref_known[ref_disp][a]) begin
        n_vec++;
        if (rd_data !== ref_bank[ref_disp][a]) begin
          n_err++;
          $display("FAIL %s display addr %0d: got %b want %b", tag, a, rd_data,
                   ref_bank[ref_disp][a]);
        end
      end
    end
  endtask

  task automatic pulse_frame(input string tag);
    @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    if (ref_pend) begin
      ref_disp = 1 - ref_disp;
      ref_pend = 1'b0;
      ref_err  = 1'b0;
    end
    #1;
    n_vec += 3;
    if (pending !== ref_pend) begin
      n_err++;
      $display("FAIL %s frame pending: got %b want %b", tag, pending, ref_pend);
    end
    if (err !== ref_err) begin
      n_err++;
      $display("FAIL %s frame err: got %b want %b", tag, err, ref_err);
    end
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s frame ready: got %b want 1", tag, in_ready);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 6'(a);
      #1;
      if (ref_known[ref_disp][a]) begin
        n_vec++;
        if (rd_data !== ref_bank[ref_disp][a]) begin
          n_err++;
          $display("FAIL %s frame addr %0d: got %b want %b", tag, a, rd_data,
                   ref_bank[ref_disp][a]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 1'b0;
    in_last  = 1'b0;
    frame    = 1'b0;
    clear    = 1'b0;
    rd_addr  = '0;
    ref_disp = 0;
    ref_pend = 1'b0;
    ref_err  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset ready during rst: got %b want 0", in_ready);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_vec += 3;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset ready: got %b want 1", in_ready);
    end
    if (pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset pending: got %b want 0", pending);
    end
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL reset err: got %b want 0", err);
    end
  endtask

  task automatic test_basic();
    stream(DEPTH, 0, 1'b0, 1'b0, "basic");
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic ready while pending: got %b want 0", in_ready);
    end
    pulse_frame("basic");
    @(negedge clk);
    rd_addr = 6'd5;
    #1;
    n_vec++;
    if (rd_data !== 1'b1) begin
      n_err++;
      $display("FAIL basic rd_addr5: got %b want 1", rd_data);
    end
    rd_addr = 6'd6;
    #1;
    n_vec++;
    if (rd_data !== 1'b0) begin
      n_err++;
      $display("FAIL basic rd_addr6: got %b want 0", rd_data);
    end
  endtask

  task automatic test_hold();
    stream(DEPTH, 1, 1'b1, 1'b0, "hold");
    repeat ($urandom_range(3, 8)) begin
      @(negedge clk);
      #1;
      n_vec += 2;
      if (pending !== 1'b1) begin
        n_err++;
        $display("FAIL hold pending: got %b want 1", pending);
      end
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold ready: got %b want 0", in_ready);
      end
    end
    pulse_frame("hold");
  endtask

  task automatic test_short();
    stream(11, 2, 1'b0, 1'b0, "short");
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL short ready after error: got %b want 1", in_ready);
    end
    pulse_frame("short_noswap");
    stream(DEPTH, 2, 1'b1, 1'b0, "short_good");
    pulse_frame("short_commit");
  endtask

  task automatic test_overlong();
    stream(70, 2, 1'b0, 1'b0, "overlong");
    pulse_frame("overlong_noswap");
  endtask

  task automatic test_coincident();
    stream(DEPTH, 2, 1'b1, 1'b1, "coinc");
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 1'($urandom_range(1));
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL coinc ready while pending: got %b want 0", in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    pulse_frame("coinc");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int n;
      case ($urandom_range(2))
        0:       n = DEPTH;
        1:       n = $urandom_range(1, DEPTH - 1);
        default: n = $urandom_range(DEPTH + 1, DEPTH + 12);
      endcase
      stream(n, 2, 1'b1, 1'($urandom_range(1)), "random");
      pulse_frame("random");
    end
  endtask

`ifdef SPRITE_LOADER_CLEAR_EN
  task automatic test_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL clear ready on request: got %b want 0", in_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      n_vec += 2;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL clear ready cycle %0d: got %b want 0", k, in_ready);
      end
      if (pending !== 1'b0) begin
        n_err++;
        $display("FAIL clear early pending cycle %0d: got %b want 0", k, pending);
      end
      @(negedge clk);
    end
    for (int a = 0; a < DEPTH; a++) begin
      ref_bank[1 - ref_disp][a]  = 1'b0;
      ref_known[1 - ref_disp][a] = 1'b1;
    end
    ref_pend = 1'b1;
    #1;
    n_vec++;
    if (pending !== 1'b1) begin
      n_err++;
      $display("FAIL clear pending: got %b want 1", pending);
    end
    pulse_frame("clear");
  endtask
`endif

  task automatic test_reset_midload();
    int wb;
    wb = 1 - ref_disp;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = 1'($urandom_range(1));
      ref_bank[wb][i]  = in_data;
      ref_known[wb][i] = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    ref_disp = 0;
    ref_pend = 1'b0;
    ref_err  = 1'b0;
    #1;
    n_vec += 2;
    if (pending !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL midrst flags: got pending=%b err=%b want 0 0", pending, err);
    end
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst ready: got %b want 1", in_ready);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 6'(a);
      #1;
      if (ref_known[0][a]) begin
        n_vec++;
        if (rd_data !== ref_bank[0][a]) begin
          n_err++;
          $display("FAIL midrst bank0 addr %0d: got %b want %b", a, rd_data, ref_bank[0][a]);
        end
      end
    end
    stream(DEPTH, 2, 1'b1, 1'b0, "midrst_reload");
    pulse_frame("midrst_reload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_short();
    test_overlong();
    test_coincident();
    test_random();
`ifdef SPRITE_LOADER_CLEAR_EN
    test_clear();
`endif
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
